// File: rtl/alu_arbiter.sv
// Purpose : shares one 32-bit ALU between two requesters with round-robin or fixed-priority arbitration.
// Latency : accept at edge T, EXEC over T..T+1, response valid after T+1, minimum 3 cycles per op.
// Backpr. : new requests are refused (ReqReady=0) until the owner takes its response via RspReady.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   ReqValid/ReqReady [1:0]         per-requester request handshake
//   ReqSrcA*/ReqSrcB*/ReqOp*        operands and ALU op for requester 0/1
//   RspValid/RspReady [1:0]         per-requester response handshake
//   RspResult, RspFlags             registered result and {N, Z, C, V}
//   SrcA, SrcB, ALUControl          operands/op driven to the external ALU
//   ALUResult, Zero/Negative/...    combinational ALU outputs
//   GrantCnt0/1                     wrapping accepted-operation counters
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module alu_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       ReqValid,
   output logic [1:0]       ReqReady,
   input  logic [31:0]      ReqSrcA0,
   input  logic [31:0]      ReqSrcA1,
   input  logic [31:0]      ReqSrcB0,
   input  logic [31:0]      ReqSrcB1,
   input  logic [1:0]       ReqOp0,
   input  logic [1:0]       ReqOp1,
   output logic [1:0]       RspValid,
   input  logic [1:0]       RspReady,
   output logic [31:0]      RspResult,
   output logic [3:0]       RspFlags,
   output logic [31:0]      SrcA,
   output logic [31:0]      SrcB,
   output logic [1:0]       ALUControl,
   input  logic [31:0]      ALUResult,
   input  logic             Zero,
   input  logic             Negative,
   input  logic             Overflow,
   input  logic             Carry,
   output logic [CNT_W-1:0] GrantCnt0,
   output logic [CNT_W-1:0] GrantCnt1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_last;
   logic             r_owner;
   logic [31:0]      r_op_a;
   logic [31:0]      r_op_b;
   logic [1:0]       r_op_c;
   logic [31:0]      r_result;
   logic [3:0]       r_flags;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   logic             w_any;
   logic             w_both;
   logic             w_win;
   logic [31:0]      w_a;
   logic [31:0]      w_b;
   logic [1:0]       w_c;

   assign w_any  = |ReqValid;
   assign w_both = &ReqValid;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Requester 1 wins only when requester 0 is idle; r_last is tracked but unused.
   assign w_win = ~ReqValid[0];
`else
   // On a tie the requester that was not granted last time wins.
   assign w_win = w_both ? ~r_last : ReqValid[1];
`endif

   assign w_a = w_win ? ReqSrcA1 : ReqSrcA0;
   assign w_b = w_win ? ReqSrcB1 : ReqSrcB0;
   assign w_c = w_win ? ReqOp1   : ReqOp0;

   // Ready is purely a function of state, last and ReqValid: no path from RspReady.
   always_comb begin
      ReqReady = 2'b00;
      if (r_state == IDLE && w_any) begin
         ReqReady[w_win] = 1'b1;
      end
   end

   always_comb begin
      RspValid = 2'b00;
      if (r_state == RESP) begin
         RspValid[r_owner] = 1'b1;
      end
   end

   assign SrcA       = r_op_a;
   assign SrcB       = r_op_b;
   assign ALUControl = r_op_c;
   assign RspResult  = r_result;
   assign RspFlags   = r_flags;
   assign GrantCnt0  = r_cnt0;
   assign GrantCnt1  = r_cnt1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_last   <= 1'b1;
         r_owner  <= 1'b0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_op_c   <= '0;
         r_result <= '0;
         r_flags  <= '0;
         r_cnt0   <= '0;
         r_cnt1   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_op_a  <= w_a;
                  r_op_b  <= w_b;
                  r_op_c  <= w_c;
                  r_owner <= w_win;
                  r_last  <= w_win;
                  if (w_win) begin
                     r_cnt1 <= r_cnt1 + 1'b1;
                  end else begin
                     r_cnt0 <= r_cnt0 + 1'b1;
                  end
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_result <= ALUResult;
               r_flags  <= {Negative, Zero, Carry, Overflow};
               r_state  <= RESP;
            end
            RESP: begin
               if (RspReady[r_owner]) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
